zorro2_autoconfig: RTL and testbench
====================================

// Module: zorro2_autoconfig
// PURPOSE
//  Zorro II AutoConfig responder for the IDE board. Answers config-space reads at $E8xxxx,
//  latches the 128K base address assigned by the OS, and drives the daisy-chain CFGOUT_n.
//  Its ide_access output feeds the IDE decode/strobe stage.
// PARAMETERS
//  MANUF_ID    16'h07DB      manufacturer ID, returned inverted at $10-$16
//  PRODUCT_ID  8'h05         product ID, returned inverted at $04/$06
//  SERIAL      32'h00000001  serial number, returned inverted at $18-$26
//  DIAG_VEC    16'h4000      boot ROM diag vector offset, returned inverted at $28-$2E
// PORTS
//  CLK         in   1   7 MHz bus clock
//  RESET_n     in   1   asynchronous, active-low reset
//  ADDR        in   23  CPU address A23..A1
//  DIN         in   4   data D15..D12, write data
//  UDS_n       in   1   upper data strobe
//  RW          in   1   1 = read, 0 = write
//  AS_n        in   1   address strobe
//  CFGIN_n     in   1   chain input; low = this board may configure
//  BOARD_EN    in   1   jumper; low = board disabled, acts as SHUTUP
//  DOUT        out  4   config nibble for D15..D12
//  DOE         out  1   drive enable for DOUT
//  CFGOUT_n    out  1   chain output to next board
//  ide_access  out  1   cycle targets assigned 128K window
// BEHAVIOUR
//  - Reset: state=UNCONF, base=8'h00, DOE=0, DOUT=4'hF, CFGOUT_n=1, ide_access=0, wr_done=0.
//  - cfg_hit = !AS_n && ADDR[23:16]==8'hE8 && !CFGIN_n && state==UNCONF && BOARD_EN.
//  - States: UNCONF -> CONFIGURED on write $48; UNCONF -> SHUTUP on write $4C.
//    CONFIGURED and SHUTUP exit only by reset. BOARD_EN low at reset exit forces SHUTUP
//    on first CLK.
//  - Write commit: first CLK rising edge with cfg_hit && !RW && !UDS_n && !wr_done.
//    Commit sets wr_done; wr_done clears on a CLK edge with AS_n high.
//    One commit per bus cycle, regardless of cycle length.
//  - Write $4A: base[3:0]<=DIN. Write $48: base[7:4]<=DIN, state<=CONFIGURED.
//    $48 in the same cycle as nothing prior still configures; base[3:0] keeps its prior value.
//  - Register offset = {ADDR[7:1],1'b0}. Read data is registered, 1 CLK after AS_n falls.
//    DOE = cfg_hit && RW, combinational; it drops with AS_n.
//  - Read map (nibble on D15..D12):
//    $00 er_type[7:4], $02 er_type[3:0]; not inverted.
//    $04/$06 ~PRODUCT_ID; $08/$0A ~8'h00 (flags).
//    $10-$16 ~MANUF_ID, MSN first; $18-$26 ~SERIAL, MSN first.
//    $28-$2E ~DIAG_VEC; $40/$42 4'h0; all other offsets 4'hF.
//  - er_type = {2'b11,1'b0,ROMV,1'b0,3'b010}: Zorro II, not memory, no link, 128K.
//  - CFGOUT_n goes low on the first CLK edge with AS_n high after entering
//    CONFIGURED/SHUTUP, never mid-cycle. It stays low until reset.
//  - ide_access = state==CONFIGURED && !AS_n && ADDR[23:17]==base[7:1]; base[0] is ignored.
//  - Reset asserted mid-cycle returns all state to reset values immediately; no partial commit.
//  - Writes to config space while CONFIGURED, SHUTUP or CFGIN_n high are ignored; DOE stays 0.
// CONFIGURATION
//  - AUTOBOOT_ROM_EN defined:
//    ROMV=1, er_type=8'hD2, $28-$2E return ~DIAG_VEC.
//  - AUTOBOOT_ROM_EN undefined:
//    ROMV=0, er_type=8'hC2, $28-$2E return 4'hF, DIAG_VEC unused.
// TESTING
//  1. Reset, CFGIN_n=0; read $E80000,$E80002 -> DOUT D,2 (AUTOBOOT_ROM_EN) / C,2 without; DOE=1.
//  2. Read $E80010-$E80016 with MANUF_ID=07DB -> F,8,2,4; read $E80044 -> F.
//  3. Write $E8004A DIN=0, then $E80048 DIN=E -> base=E0.
//     CFGOUT_n low on first edge after AS_n high.
//     Access $E10000 -> ide_access=1; access $E20000 -> ide_access=0.
//  4. Write $E8004C -> SHUTUP: CFGOUT_n low after cycle; a later read of $E80000 gives DOE=0;
//     ide_access never asserts.
//  5. CFGIN_n=1: read/write $E80000-$E8004C -> DOE=0, state stays UNCONF, CFGOUT_n=1.
//  6. Write $48 cycle held 6 CLKs -> single commit; RESET_n pulsed mid-cycle
//     -> UNCONF, base=00, CFGOUT_n=1.

Source files
------------

// File: rtl/zorro2_autoconfig_if.sv
// Zorro II bus signals seen by the AutoConfig responder: address, strobes, config data nibble.
interface zorro2_autoconfig_if;
  logic [23:1] ADDR;
  logic [3:0]  DIN;
  logic        UDS_n;
  logic        RW;
  logic        AS_n;
  logic [3:0]  DOUT;
  logic        DOE;

  modport master (
    output ADDR, DIN, UDS_n, RW, AS_n,
    input  DOUT, DOE
  );

  modport slave (
    input  ADDR, DIN, UDS_n, RW, AS_n,
    output DOUT, DOE
  );
endinterface

// File: rtl/zorro2_autoconfig.sv
// Zorro II AutoConfig responder for the IDE board: config-space reads, 128K base latch, CFGOUT_n chain.
// Optional boot ROM vector advertised when AUTOBOOT_ROM_EN is defined.
module zorro2_autoconfig #(
  parameter logic [15:0] MANUF_ID   = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID = 8'h05,
  parameter logic [31:0] SERIAL     = 32'h00000001,
  parameter logic [15:0] DIAG_VEC   = 16'h4000
) (
  input  logic                CLK,
  input  logic                RESET_n,
  zorro2_autoconfig_if.slave  bus,
  input  logic                CFGIN_n,
  input  logic                BOARD_EN,
  output logic                CFGOUT_n,
  output logic                ide_access
);

`ifdef AUTOBOOT_ROM_EN
  localparam logic        ROMV   = 1'b1;
  localparam logic [15:0] DIAG_N = ~DIAG_VEC;
`else
  localparam logic        ROMV   = 1'b0;
`endif
  localparam logic [7:0]  ER_TYPE  = {2'b11, 1'b0, ROMV, 1'b0, 3'b010};
  localparam logic [7:0]  PROD_N   = ~PRODUCT_ID;
  localparam logic [15:0] MANUF_N  = ~MANUF_ID;
  localparam logic [31:0] SERIAL_N = ~SERIAL;

  typedef enum logic [1:0] {
    ST_UNCONF     = 2'd0,
    ST_CONFIGURED = 2'd1,
    ST_SHUTUP     = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_base, w_base_nxt;
  logic        r_wr_done, w_wr_done_nxt;
  logic        r_cfgout_n, w_cfgout_n_nxt;
  logic [3:0]  r_dout, w_dout_nxt;

  logic        w_cfg_hit;
  logic        w_commit;
  logic [7:0]  w_offset;
  logic [3:0]  w_rd_nib;
  logic        w_unused;

  assign w_cfg_hit = !bus.AS_n && (bus.ADDR[23:16] == 8'hE8) && !CFGIN_n &&
                     (r_state == ST_UNCONF) && BOARD_EN;
  assign w_offset  = {bus.ADDR[7:1], 1'b0};
  assign w_commit  = w_cfg_hit && !bus.RW && !bus.UDS_n && !r_wr_done;

  assign bus.DOE    = w_cfg_hit && bus.RW;
  assign bus.DOUT   = r_dout;
  assign CFGOUT_n   = r_cfgout_n;
  assign ide_access = (r_state == ST_CONFIGURED) && !bus.AS_n &&
                      (bus.ADDR[23:17] == r_base[7:1]);

`ifdef AUTOBOOT_ROM_EN
  assign w_unused = ^{bus.ADDR[15:8], r_base[0]};
`else
  assign w_unused = ^{bus.ADDR[15:8], r_base[0], DIAG_VEC};
`endif

  // Config ROM nibble map; identity fields are presented inverted on the bus
  always_comb begin
    w_rd_nib = 4'hF;
    case (w_offset)
      8'h00: w_rd_nib = ER_TYPE[7:4];
      8'h02: w_rd_nib = ER_TYPE[3:0];
      8'h04: w_rd_nib = PROD_N[7:4];
      8'h06: w_rd_nib = PROD_N[3:0];
      8'h10: w_rd_nib = MANUF_N[15:12];
      8'h12: w_rd_nib = MANUF_N[11:8];
      8'h14: w_rd_nib = MANUF_N[7:4];
      8'h16: w_rd_nib = MANUF_N[3:0];
      8'h18: w_rd_nib = SERIAL_N[31:28];
      8'h1A: w_rd_nib = SERIAL_N[27:24];
      8'h1C: w_rd_nib = SERIAL_N[23:20];
      8'h1E: w_rd_nib = SERIAL_N[19:16];
      8'h20: w_rd_nib = SERIAL_N[15:12];
      8'h22: w_rd_nib = SERIAL_N[11:8];
      8'h24: w_rd_nib = SERIAL_N[7:4];
      8'h26: w_rd_nib = SERIAL_N[3:0];
`ifdef AUTOBOOT_ROM_EN
      8'h28: w_rd_nib = DIAG_N[15:12];
      8'h2A: w_rd_nib = DIAG_N[11:8];
      8'h2C: w_rd_nib = DIAG_N[7:4];
      8'h2E: w_rd_nib = DIAG_N[3:0];
`endif
      8'h40: w_rd_nib = 4'h0;
      8'h42: w_rd_nib = 4'h0;
      default: w_rd_nib = 4'hF;
    endcase
  end

  // Next state: one write commit per bus cycle, chain output released only between cycles
  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_wr_done_nxt  = r_wr_done;
    w_cfgout_n_nxt = r_cfgout_n;
    w_dout_nxt     = (w_cfg_hit && bus.RW) ? w_rd_nib : 4'hF;

    if (bus.AS_n) w_wr_done_nxt = 1'b0;

    if (w_commit) begin
      w_wr_done_nxt = 1'b1;
      case (w_offset)
        8'h4A: w_base_nxt[3:0] = bus.DIN;
        8'h48: begin
          w_base_nxt[7:4] = bus.DIN;
          w_state_nxt     = ST_CONFIGURED;
        end
        8'h4C: w_state_nxt = ST_SHUTUP;
        default: ;
      endcase
    end

    if ((r_state == ST_UNCONF) && !BOARD_EN) w_state_nxt = ST_SHUTUP;

    if ((r_state != ST_UNCONF) && bus.AS_n) w_cfgout_n_nxt = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= ST_UNCONF;
      r_base     <= 8'h00;
      r_wr_done  <= 1'b0;
      r_cfgout_n <= 1'b1;
      r_dout     <= 4'hF;
    end else begin
      r_state    <= w_state_nxt;
      r_base     <= w_base_nxt;
      r_wr_done  <= w_wr_done_nxt;
      r_cfgout_n <= w_cfgout_n_nxt;
      r_dout     <= w_dout_nxt;
    end
  end

endmodule

// File: tb/tb_zorro2_autoconfig.sv
// Directed bench for zorro2_autoconfig: config reads, base assignment, shutup, chain and reset behaviour.
module tb_zorro2_autoconfig;
  logic CLK      = 1'b0;
  logic RESET_n  = 1'b0;
  logic CFGIN_n  = 1'b0;
  logic BOARD_EN = 1'b1;
  logic CFGOUT_n;
  logic ide_access;

  int checks   = 0;
  int failures = 0;

  zorro2_autoconfig_if bus ();

  zorro2_autoconfig dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .bus        (bus),
    .CFGIN_n    (CFGIN_n),
    .BOARD_EN   (BOARD_EN),
    .CFGOUT_n   (CFGOUT_n),
    .ide_access (ide_access)
  );

  always #5 CLK = ~CLK;

`ifdef AUTOBOOT_ROM_EN
  localparam logic [3:0] EXP_ER_HI = 4'hD;
  localparam logic [3:0] EXP_DIAG0 = 4'hB;
`else
  localparam logic [3:0] EXP_ER_HI = 4'hC;
  localparam logic [3:0] EXP_DIAG0 = 4'hF;
`endif

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.AS_n  = 1'b1;
    bus.UDS_n = 1'b1;
    bus.RW    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    bus_idle();
    RESET_n = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);
  endtask

  // Read cycle: data sampled two edges after AS_n falls, then strobes released
  task automatic rd(input logic [23:0] a, output logic [3:0] d, output logic oe, output logic ide);
    @(negedge CLK);
    bus.ADDR  = a[23:1];
    bus.RW    = 1'b1;
    bus.UDS_n = 1'b0;
    bus.AS_n  = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    d   = bus.DOUT;
    oe  = bus.DOE;
    ide = ide_access;
    @(negedge CLK);
    bus_idle();
    @(posedge CLK);
    #1;
  endtask

  // Write cycle held 'hold' edges; DIN switches to d1 after the first edge
  task automatic wr(input logic [23:0] a, input logic [3:0] d0, input logic [3:0] d1,
                    input int hold, output logic cfg_mid, output logic cfg_after);
    @(negedge CLK);
    bus.ADDR  = a[23:1];
    bus.DIN   = d0;
    bus.RW    = 1'b0;
    bus.UDS_n = 1'b0;
    bus.AS_n  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    bus.DIN = d1;
    repeat (hold - 1) @(posedge CLK);
    #1;
    cfg_mid = CFGOUT_n;
    @(negedge CLK);
    bus_idle();
    @(posedge CLK);
    #1;
    cfg_after = CFGOUT_n;
  endtask

  logic [3:0]  d;
  logic        oe, ide, cm, ca;
  logic [23:0] rd_addr [12];
  logic [3:0]  rd_exp  [12];

  initial begin
    bus_idle();
    bus.ADDR = '0;
    bus.DIN  = '0;
    repeat (2) @(negedge CLK);
    check("rst_dout", 8'(bus.DOUT), 8'hF);
    check("rst_doe", 8'(bus.DOE), 8'h0);
    check("rst_cfgout", 8'(CFGOUT_n), 8'h1);
    check("rst_ide", 8'(ide_access), 8'h0);
    RESET_n = 1'b1;
    @(negedge CLK);

    // Config ROM read table
    rd_addr = '{24'hE80000, 24'hE80002, 24'hE80004, 24'hE80006, 24'hE80008, 24'hE80010,
                24'hE80012, 24'hE80014, 24'hE80016, 24'hE80026, 24'hE80028, 24'hE80040};
    rd_exp  = '{EXP_ER_HI, 4'h2, 4'hF, 4'hA, 4'hF, 4'hF,
                4'h8, 4'h2, 4'h4, 4'hE, EXP_DIAG0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      rd(rd_addr[i], d, oe, ide);
      check($sformatf("rd_%02h", rd_addr[i][7:0]), 8'(d), 8'(rd_exp[i]));
      check($sformatf("doe_%02h", rd_addr[i][7:0]), 8'(oe), 8'h1);
    end
    rd(24'hE80044, d, oe, ide);
    check("rd_44", 8'(d), 8'hF);
    check("doe_drop", 8'(bus.DOE), 8'h0);

    // Assign base E0
    wr(24'hE8004A, 4'h0, 4'h0, 2, cm, ca);
    check("cfgout_after_4a", 8'(ca), 8'h1);
    wr(24'hE80048, 4'hE, 4'hE, 3, cm, ca);
    check("cfgout_mid_48", 8'(cm), 8'h1);
    check("cfgout_after_48", 8'(ca), 8'h0);
    rd(24'hE10000, d, oe, ide);
    check("ide_e1", 8'(ide), 8'h1);
    rd(24'hE20000, d, oe, ide);
    check("ide_e2", 8'(ide), 8'h0);
    rd(24'hE80000, d, oe, ide);
    check("doe_configured", 8'(oe), 8'h0);
    check("ide_cfgspace", 8'(ide), 8'h0);

    // Shutup
    do_reset();
    check("cfgout_reset2", 8'(CFGOUT_n), 8'h1);
    wr(24'hE8004C, 4'h0, 4'h0, 2, cm, ca);
    check("cfgout_mid_4c", 8'(cm), 8'h1);
    check("cfgout_after_4c", 8'(ca), 8'h0);
    rd(24'hE80000, d, oe, ide);
    check("doe_shutup", 8'(oe), 8'h0);
    rd(24'h000000, d, oe, ide);
    check("ide_shutup", 8'(ide), 8'h0);

    // Chain input high: board must stay invisible and unconfigured
    do_reset();
    CFGIN_n = 1'b1;
    rd(24'hE80000, d, oe, ide);
    check("doe_cfgin_hi", 8'(oe), 8'h0);
    wr(24'hE80048, 4'hE, 4'hE, 2, cm, ca);
    check("cfgout_cfgin_hi", 8'(ca), 8'h1);
    wr(24'hE8004C, 4'h0, 4'h0, 2, cm, ca);
    check("cfgout_cfgin_hi_4c", 8'(ca), 8'h1);
    CFGIN_n = 1'b0;
    rd(24'hE80002, d, oe, ide);
    check("doe_still_unconf", 8'(oe), 8'h1);
    check("rd_still_unconf", 8'(d), 8'h2);

    // Long write cycles commit once: base low nibble keeps its first value
    wr(24'hE8004A, 4'h2, 4'h4, 6, cm, ca);
    wr(24'hE80048, 4'h0, 4'h6, 6, cm, ca);
    check("cfgout_mid_long", 8'(cm), 8'h1);
    check("cfgout_after_long", 8'(ca), 8'h0);
    rd(24'h020000, d, oe, ide);
    check("ide_base02", 8'(ide), 8'h1);
    rd(24'h040000, d, oe, ide);
    check("ide_base04", 8'(ide), 8'h0);
    rd(24'h600000, d, oe, ide);
    check("ide_base60", 8'(ide), 8'h0);

    // Reset pulsed in the middle of a cycle
    @(negedge CLK);
    bus.ADDR  = 23'(24'h020000 >> 1);
    bus.RW    = 1'b1;
    bus.UDS_n = 1'b0;
    bus.AS_n  = 1'b0;
    #1;
    check("ide_before_rst", 8'(ide_access), 8'h1);
    @(posedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    check("ide_mid_rst", 8'(ide_access), 8'h0);
    check("cfgout_mid_rst", 8'(CFGOUT_n), 8'h1);
    @(negedge CLK);
    bus_idle();
    RESET_n = 1'b1;
    @(negedge CLK);
    rd(24'hE80000, d, oe, ide);
    check("doe_after_rst", 8'(oe), 8'h1);
    wr(24'hE80048, 4'h0, 4'h0, 2, cm, ca);
    rd(24'h000000, d, oe, ide);
    check("ide_base00", 8'(ide), 8'h1);

    // Board disabled by jumper becomes SHUTUP after reset
    BOARD_EN = 1'b0;
    do_reset();
    @(posedge CLK);
    #1;
    check("cfgout_board_dis", 8'(CFGOUT_n), 8'h0);
    BOARD_EN = 1'b1;
    rd(24'hE80000, d, oe, ide);
    check("doe_board_dis", 8'(oe), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
